// File: rtl/serial_mag_comp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types for the serial magnitude comparator: the controller state
// encoding, the one-hot result record and a helper that turns the
// single-bit "A greater" decision into a full verdict.
// -----------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   localparam cmp_res_t RES_NONE = 3'b000;
   localparam cmp_res_t RES_EQ   = 3'b010;

   // Verdict for the first differing bit: exactly one of gt/lt is set.
   function automatic cmp_res_t verdict(input logic bit_gt);
      cmp_res_t res;
      res.gt = bit_gt;
      res.eq = 1'b0;
      res.lt = ~bit_gt;
      return res;
   endfunction

endpackage

// File: rtl/serial_mag_comp_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_ctrl_if
// Operand and result handshakes of the serial magnitude comparator.
//   in_valid/in_ready/a/b        : operand pair, valid/ready
//   out_valid/out_ready/gt/eq/lt : one-hot result, valid/ready
//   busy, bits_used              : status
// The master modport is the producer/consumer side, the slave modport is
// the comparator.
// -----------------------------------------------------------------------------
interface serial_mag_comp_ctrl_if #(
   parameter int WIDTH = 4
);
   localparam int BW = $clog2(WIDTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             busy;
   logic [BW-1:0]    bits_used;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, gt, eq, lt, busy, bits_used
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, gt, eq, lt, busy, bits_used
   );

endinterface

// File: rtl/serial_mag_comp_ctrl_slice.sv
// -----------------------------------------------------------------------------
// bit_cmp_slice
// Single-bit compare slice, purely combinational.
//   i0, i1 : the two operand bits (A, B)
//   eq     : i0 == i1 (sum-of-products XNOR)
//   gt     : i0 > i1
// -----------------------------------------------------------------------------
module bit_cmp_slice (
   input  logic i0,
   input  logic i1,
   output logic eq,
   output logic gt
);

   assign eq = (i0 & i1) | (~i0 & ~i1);
   assign gt = i0 & ~i1;

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_ctrl
// N-bit unsigned magnitude comparator built from one time-shared single-bit
// compare slice. An operand pair is accepted in IDLE, scanned MSB first one
// bit per clock in SCAN, and the one-hot result is presented in DONE until
// the consumer takes it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of serial_mag_comp_ctrl_if (operand/result
//              handshakes, busy, bits_used)
// Parameters:
//   WIDTH      : operand width, 2..32
//   EARLY_EXIT : 1 = stop at the first differing bit, 0 = constant latency
// -----------------------------------------------------------------------------
module serial_mag_comp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_mag_comp_ctrl_if.slave bus
);

   localparam int IW = $clog2(WIDTH);
   localparam int BW = IW + 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   cmp_res_t         r_res;
   logic             r_decided;   // a differing bit has already fixed the verdict
   logic             r_out_valid;
   logic             r_busy;
   logic [BW-1:0]    r_bits_used;

   logic w_bit_a;
   logic w_bit_b;
   logic w_bit_eq;
   logic w_bit_gt;
   logic w_exit;
   logic w_accept;

   // The one shared slice always looks at the bit selected by r_idx.
   assign w_bit_a = r_a[r_idx];
   assign w_bit_b = r_b[r_idx];

   bit_cmp_slice u_slice (
      .i0 (w_bit_a),
      .i1 (w_bit_b),
      .eq (w_bit_eq),
      .gt (w_bit_gt)
   );

   // Bit 0 is always the last one scanned, so idx never has to wrap.
   assign w_exit = (EARLY_EXIT && !w_bit_eq) || (r_idx == '0);

   // Gated by rst so no handshake can complete while reset is held.
   assign bus.in_ready = (r_state == IDLE) && !rst;
   assign w_accept     = bus.in_valid && bus.in_ready;

   // NOTE: every register here is state updated on the clock edge, so all
   // assignments are non-blocking; blocking ones would let later statements
   // see this cycle's new values and break the one-bit-per-clock scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         // NOTE: the operand registers are plain flops, not a memory, so
         // resetting them is cheap and keeps the slice inputs defined.
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= '0;
         r_res       <= RES_NONE;
         r_decided   <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_bits_used <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a       <= bus.a;
                  r_b       <= bus.b;
                  r_idx     <= IW'(WIDTH - 1);
                  r_res     <= RES_NONE;
                  r_decided <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= SCAN;
               end
            end

            SCAN: begin
               // Only the most significant differing bit decides; later bits
               // are still scanned when EARLY_EXIT=0 but cannot overwrite it.
               if (!r_decided && !w_bit_eq) begin
                  r_res     <= verdict(w_bit_gt);
                  r_decided <= 1'b1;
               end
               if (w_exit) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_bits_used <= BW'(WIDTH) - BW'(r_idx);
                  if (!r_decided && w_bit_eq) begin
                     r_res <= RES_EQ;
                  end
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.gt        = r_res.gt;
   assign bus.eq        = r_res.eq;
   assign bus.lt        = r_res.lt;
   assign bus.busy      = r_busy;
   assign bus.bits_used = r_bits_used;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp_ctrl
// Two comparators (EARLY_EXIT=0 as dut 0, EARLY_EXIT=1 as dut 1) share the
// operand stimulus and have independent out_ready. A forked monitor pushes
// the expected result and latency into a per-dut queue at every accepted
// handshake and checks them while the result is presented.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp_ctrl;

   localparam int W = 4;

   typedef struct {
      logic [2:0] res;     // {gt, eq, lt}
      int         t_acc;   // cycle in which the accept handshake was seen
      int         n;       // bits examined
   } exp_t;

   logic       clk;
   logic       rst;
   logic       tb_in_valid;
   logic [W-1:0] tb_a;
   logic [W-1:0] tb_b;
   logic       rdy0;
   logic       rdy1;
   logic       rand_rdy;

   int n_cmp;
   int n_fail;
   int cyc;

   exp_t q0[$];
   exp_t q1[$];
   bit   seen0;
   bit   seen1;

   serial_mag_comp_ctrl_if #(.WIDTH(W)) if0 ();
   serial_mag_comp_ctrl_if #(.WIDTH(W)) if1 ();

   assign if0.in_valid  = tb_in_valid;
   assign if0.a         = tb_a;
   assign if0.b         = tb_b;
   assign if0.out_ready = rdy0;
   assign if1.in_valid  = tb_in_valid;
   assign if1.a         = tb_a;
   assign if1.b         = tb_b;
   assign if1.out_ready = rdy1;

   serial_mag_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   serial_mag_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- model
   function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
      return {x > y, x == y, x < y};
   endfunction

   function automatic int model_n(input bit early, input logic [W-1:0] x, input logic [W-1:0] y);
      int  n;
      bit  found;
      n     = W;
      found = 1'b0;
      if (early) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (!found && (x[i] != y[i])) begin
               n     = W - i;
               found = 1'b1;
            end
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   task automatic mon_one(input int d, input logic ir, input logic ov, input logic ordy,
                          input logic [2:0] res, input logic busy, input logic [2:0] bu);
      exp_t  e;
      string p;
      int    qs;
      bit    seen;
      p = $sformatf("dut%0d", d);
      if (ir && tb_in_valid) begin
         e.res   = model_res(tb_a, tb_b);
         e.t_acc = cyc;
         e.n     = model_n(d == 1, tb_a, tb_b);
         if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (ov) begin
         qs = (d == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            check({p, "_spurious_result"}, 32'(ov), 32'd0);
         end else begin
            e    = (d == 0) ? q0[0] : q1[0];
            seen = (d == 0) ? seen0 : seen1;
            if (!seen) begin
               check({p, "_latency"}, cyc, e.t_acc + 1 + e.n);
               if (d == 0) seen0 = 1'b1; else seen1 = 1'b1;
            end
            check({p, "_result_gt_eq_lt"}, 32'(res), 32'(e.res));
            check({p, "_bits_used"}, 32'(bu), e.n);
            check({p, "_busy_in_done"}, 32'(busy), 32'd1);
            check({p, "_in_ready_in_done"}, 32'(ir), 32'd0);
            if (ordy) begin
               if (d == 0) begin void'(q0.pop_front()); seen0 = 1'b0; end
               else        begin void'(q1.pop_front()); seen1 = 1'b0; end
            end
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) begin
            q0.delete();
            q1.delete();
            seen0 = 1'b0;
            seen1 = 1'b0;
         end else begin
            mon_one(0, if0.in_ready, if0.out_valid, if0.out_ready,
                    {if0.gt, if0.eq, if0.lt}, if0.busy, if0.bits_used);
            mon_one(1, if1.in_ready, if1.out_valid, if1.out_ready,
                    {if1.gt, if1.eq, if1.lt}, if1.busy, if1.bits_used);
         end
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
      int k;
      k = 0;
      while (!(if0.in_ready && if1.in_ready) && (k < 200)) begin
         @(posedge clk); #1;
         k++;
      end
      check("send_both_idle", 32'(if0.in_ready && if1.in_ready), 32'd1);
      tb_a        = va;
      tb_b        = vb;
      tb_in_valid = 1'b1;
      @(posedge clk); #1;
      tb_in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         if (rand_rdy) begin
            rdy0 = ($urandom_range(0, 3) != 0);
            rdy1 = ($urandom_range(0, 3) != 0);
         end
         k++;
      end while (!(if0.in_ready && if1.in_ready) && (k < 100));
      check("wait_done_in_time", 32'(if0.in_ready && if1.in_ready), 32'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int k;
      n_cmp       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      tb_in_valid = 1'b0;
      tb_a        = '0;
      tb_b        = '0;
      rdy0        = 1'b1;
      rdy1        = 1'b1;
      rand_rdy    = 1'b0;
      seen0       = 1'b0;
      seen1       = 1'b0;
      fork
         monitor();
      join_none

      // Reset state.
      #2;
      check("rst_out_valid", 32'({if0.out_valid, if1.out_valid}), 32'd0);
      check("rst_busy", 32'({if0.busy, if1.busy}), 32'd0);
      check("rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'd0);
      check("rst_gt_eq_lt", 32'({if0.gt, if0.eq, if0.lt, if1.gt, if1.eq, if1.lt}), 32'd0);
      check("rst_bits_used", 32'({if0.bits_used, if1.bits_used}), 32'd0);
      #10;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'b11);
      @(posedge clk); #1;

      // 1: first bit differs (early exit after one bit on dut1).
      send(4'b1010, 4'b0110);
      wait_done();
      // 2: differ at bit 2, then equal operands.
      send(4'b0011, 4'b0101);
      wait_done();
      send(4'b1111, 4'b1111);
      wait_done();
      // 3: verdict at bit 3 followed by equal lower bits.
      send(4'b1000, 4'b0000);
      wait_done();

      // 4: backpressure with a second in_valid during DONE.
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      send(4'b1010, 4'b0110);
      k = 0;
      while (!(if0.out_valid && if1.out_valid) && (k < 20)) begin
         @(posedge clk); #1;
         k++;
      end
      check("bp_both_done", 32'(if0.out_valid && if1.out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tb_a        = 4'b0000;
         tb_b        = 4'b1111;
         tb_in_valid = 1'b1;
         @(posedge clk); #1;
         check("bp_in_ready_low", 32'({if0.in_ready, if1.in_ready}), 32'd0);
         check("bp_out_valid_held", 32'({if0.out_valid, if1.out_valid}), 32'b11);
         check("bp_dut1_gt_held", 32'({if1.gt, if1.eq, if1.lt, if1.bits_used}), 32'b100_001);
         check("bp_dut0_gt_held", 32'({if0.gt, if0.eq, if0.lt, if0.bits_used}), 32'b100_100);
      end
      tb_in_valid = 1'b0;
      rdy0        = 1'b1;
      rdy1        = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'b11);
      check("bp_release_out_valid", 32'({if0.out_valid, if1.out_valid}), 32'd0);

      // 5: asynchronous reset in the middle of a scan.
      send(4'b0001, 4'b0000);
      check("mid_scan_busy", 32'({if0.busy, if1.busy}), 32'b11);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'({if0.out_valid, if1.out_valid}), 32'd0);
      check("abort_busy", 32'({if0.busy, if1.busy}), 32'd0);
      check("abort_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("abort_release_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'b11);
      check("abort_bits_used", 32'({if0.bits_used, if1.bits_used}), 32'd0);
      @(posedge clk); #1;
      send(4'b0001, 4'b0010);
      wait_done();
      repeat (5) @(posedge clk);
      #1;

      // 6: exhaustive sweep with random result backpressure.
      rand_rdy = 1'b1;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            send(4'(ia), 4'(ib));
            wait_done();
         end
      end
      rand_rdy = 1'b0;
      rdy0     = 1'b1;
      rdy1     = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      check("dut0_queue_drained", q0.size(), 32'd0);
      check("dut1_queue_drained", q1.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
